// File: rtl/regfile_pkg.sv
// +----------------------------------------------------------------------------+
// | regfile_pkg: shared defaults, address-width helper, zero-register index    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ZERO_IDX = 0;

  // Width of a register address for NREG registers.
  function automatic int calc_aw(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// +----------------------------------------------------------------------------+
// | regfile_scoreboard: per-register pending bitmap (reserve / write / flush)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int NWR      = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter int AW       = calc_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush,
  output logic [NREG-1:0]     busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Order matters: flush and write-backs clear first, a reserve then re-sets.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_d[ZERO_IDX] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// +----------------------------------------------------------------------------+
// | regfile_mp: multi-port register file with write forwarding and scoreboard  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = calc_aw(NREG)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NRD*AW-1:0]   RD_I_ADDR,
  output logic [NRD*AW-1:0]   RD_O_ADDR,
  output logic [NRD*XLEN-1:0] RD_O_DATA,
  output logic [NRD-1:0]      RD_O_VALID,
  input  logic [NWR-1:0]      WR_I_EN,
  input  logic [NWR*AW-1:0]   WR_I_ADDR,
  input  logic [NWR*XLEN-1:0] WR_I_DATA,
  input  logic                RSV_I_EN,
  input  logic [AW-1:0]       RSV_I_ADDR,
  input  logic                FLUSH_I,
  output logic [NREG-1:0]     BUSY_O
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

  logic [XLEN-1:0]   mem_q [NREG];
  logic [XLEN-1:0]   mem_d [NREG];
  logic [NRD*AW-1:0] rd_addr_q;
  logic [NRD*AW-1:0] rd_addr_d;
  logic [NWR-1:0]    wr_ok;
  logic              rsv_ok;
  logic [NREG-1:0]   busy;

  // A write port is effective unless it targets the hardwired zero register.
  generate
    for (genvar j = 0; j < NWR; j++) begin : g_wr
      assign wr_ok[j] = WR_I_EN[j] &&
                        !(ZERO_REG && (WR_I_ADDR[j*AW +: AW] == ZERO_ADDR));
    end
  endgenerate

  assign rsv_ok = RSV_I_EN && !(ZERO_REG && (RSV_I_ADDR == ZERO_ADDR));

  regfile_scoreboard #(
    .NREG     (NREG),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (CLK),
    .rst      (RST),
    .wr_en    (wr_ok),
    .wr_addr  (WR_I_ADDR),
    .rsv_en   (rsv_ok),
    .rsv_addr (RSV_I_ADDR),
    .flush    (FLUSH_I),
    .busy     (busy)
  );

  assign BUSY_O = busy;

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_ok[j]) begin
        mem_d[WR_I_ADDR[j*AW +: AW]] = WR_I_DATA[j*XLEN +: XLEN];
      end
    end
    if (ZERO_REG) begin
      mem_d[ZERO_IDX] = '0;
    end
  end

  assign rd_addr_d = RD_I_ADDR;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q     <= '{default: '0};
      rd_addr_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign RD_O_ADDR = rd_addr_q;

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            valid;

      assign addr = rd_addr_q[k*AW +: AW];

      always_comb begin
        data  = mem_q[addr];
        valid = !busy[addr];
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok[j] && (WR_I_ADDR[j*AW +: AW] == addr)) begin
            data  = WR_I_DATA[j*XLEN +: XLEN];
            valid = 1'b1;
          end
        end
        if (ZERO_REG && (addr == ZERO_ADDR)) begin
          data  = '0;
          valid = 1'b1;
        end
      end

      assign RD_O_DATA[k*XLEN +: XLEN] = data;
      assign RD_O_VALID[k]             = valid;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// +----------------------------------------------------------------------------+
// | tb_regfile_mp: directed self-checking bench for regfile_mp (NRD=2, NWR=2)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                CLK;
  logic                RST;
  logic [NRD*AW-1:0]   RD_I_ADDR;
  logic [NRD*AW-1:0]   RD_O_ADDR;
  logic [NRD*XLEN-1:0] RD_O_DATA;
  logic [NRD-1:0]      RD_O_VALID;
  logic [NWR-1:0]      WR_I_EN;
  logic [NWR*AW-1:0]   WR_I_ADDR;
  logic [NWR*XLEN-1:0] WR_I_DATA;
  logic                RSV_I_EN;
  logic [AW-1:0]       RSV_I_ADDR;
  logic                FLUSH_I;
  logic [NREG-1:0]     BUSY_O;

  int checks   = 0;
  int failures = 0;

  regfile_mp #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (1'b1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RD_I_ADDR  (RD_I_ADDR),
    .RD_O_ADDR  (RD_O_ADDR),
    .RD_O_DATA  (RD_O_DATA),
    .RD_O_VALID (RD_O_VALID),
    .WR_I_EN    (WR_I_EN),
    .WR_I_ADDR  (WR_I_ADDR),
    .WR_I_DATA  (WR_I_DATA),
    .RSV_I_EN   (RSV_I_EN),
    .RSV_I_ADDR (RSV_I_ADDR),
    .FLUSH_I    (FLUSH_I),
    .BUSY_O     (BUSY_O)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_writes();
    WR_I_EN    = '0;
    WR_I_ADDR  = '0;
    WR_I_DATA  = '0;
    RSV_I_EN   = 1'b0;
    RSV_I_ADDR = '0;
    FLUSH_I    = 1'b0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    WR_I_EN[port]              = 1'b1;
    WR_I_ADDR[port*AW +: AW]   = a;
    WR_I_DATA[port*XLEN +: XLEN] = d;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_writes();
    RD_I_ADDR = '0;
    step();
    step();
    RST = 1'b0;
    RD_I_ADDR = {5'd31, 5'd5};
    step();
    #2;
    checks++;
    if (RD_O_ADDR !== {5'd31, 5'd5}) begin
      failures++;
      $display("FAIL reset_rd_addr got=%h want=%h", RD_O_ADDR, {5'd31, 5'd5});
    end
    checks++;
    if (RD_O_DATA !== 64'h0) begin
      failures++;
      $display("FAIL reset_rd_data got=%h want=0", RD_O_DATA);
    end
    checks++;
    if (RD_O_VALID !== 2'b11) begin
      failures++;
      $display("FAIL reset_rd_valid got=%b want=11", RD_O_VALID);
    end
    checks++;
    if (BUSY_O !== 32'h0) begin
      failures++;
      $display("FAIL reset_busy got=%h want=0", BUSY_O);
    end
  endtask

  task automatic test_write_read();
    wr(0, 5'd3, 32'hDEADBEEF);
    step();
    idle_writes();
    RD_I_ADDR = {5'd0, 5'd3};
    step();
    #2;
    checks++;
    if (RD_O_DATA[31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_read_x3 got=%h want=deadbeef", RD_O_DATA[31:0]);
    end
    checks++;
    if (RD_O_VALID[0] !== 1'b1) begin
      failures++;
      $display("FAIL write_read_valid got=%b want=1", RD_O_VALID[0]);
    end
  endtask

  task automatic test_forward();
    RD_I_ADDR = {5'd0, 5'd7};
    step();
    wr(0, 5'd7, 32'h1234);
    #2;
    checks++;
    if (RD_O_DATA[31:0] !== 32'h1234 || RD_O_VALID[0] !== 1'b1) begin
      failures++;
      $display("FAIL fwd_single got=%h/%b want=1234/1", RD_O_DATA[31:0], RD_O_VALID[0]);
    end
    wr(0, 5'd7, 32'h1);
    wr(1, 5'd7, 32'h2);
    #1;
    checks++;
    if (RD_O_DATA[31:0] !== 32'h2) begin
      failures++;
      $display("FAIL fwd_collide got=%h want=2", RD_O_DATA[31:0]);
    end
    step();
    idle_writes();
    #2;
    checks++;
    if (RD_O_DATA[31:0] !== 32'h2) begin
      failures++;
      $display("FAIL array_collide got=%h want=2", RD_O_DATA[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    RSV_I_EN   = 1'b1;
    RSV_I_ADDR = 5'd9;
    RD_I_ADDR  = {5'd0, 5'd9};
    step();
    idle_writes();
    #2;
    checks++;
    if (RD_O_VALID[0] !== 1'b0 || BUSY_O[9] !== 1'b1) begin
      failures++;
      $display("FAIL sb_reserved got=valid%b/busy%b want=valid0/busy1", RD_O_VALID[0], BUSY_O[9]);
    end
    wr(0, 5'd9, 32'h55);
    #1;
    checks++;
    if (RD_O_DATA[31:0] !== 32'h55 || RD_O_VALID[0] !== 1'b1) begin
      failures++;
      $display("FAIL sb_fwd got=%h/%b want=55/1", RD_O_DATA[31:0], RD_O_VALID[0]);
    end
    step();
    idle_writes();
    #2;
    checks++;
    if (BUSY_O[9] !== 1'b0 || RD_O_VALID[0] !== 1'b1 || RD_O_DATA[31:0] !== 32'h55) begin
      failures++;
      $display("FAIL sb_cleared got=busy%b/valid%b/%h want=busy0/valid1/55",
               BUSY_O[9], RD_O_VALID[0], RD_O_DATA[31:0]);
    end
    wr(0, 5'd9, 32'h66);
    RSV_I_EN   = 1'b1;
    RSV_I_ADDR = 5'd9;
    step();
    idle_writes();
    #2;
    checks++;
    if (BUSY_O[9] !== 1'b1 || RD_O_VALID[0] !== 1'b0) begin
      failures++;
      $display("FAIL sb_rsv_wins got=busy%b/valid%b want=busy1/valid0", BUSY_O[9], RD_O_VALID[0]);
    end
    checks++;
    if (RD_O_DATA[31:0] !== 32'h66) begin
      failures++;
      $display("FAIL sb_rsv_data got=%h want=66", RD_O_DATA[31:0]);
    end
  endtask

  task automatic test_flush();
    RSV_I_EN = 1'b1;
    RSV_I_ADDR = 5'd1;
    step();
    RSV_I_ADDR = 5'd2;
    step();
    RSV_I_ADDR = 5'd4;
    step();
    #2;
    checks++;
    if (BUSY_O !== 32'h0000_0216) begin
      failures++;
      $display("FAIL flush_pre got=%h want=00000216", BUSY_O);
    end
    FLUSH_I    = 1'b1;
    RSV_I_ADDR = 5'd6;
    step();
    idle_writes();
    #2;
    checks++;
    if (BUSY_O !== 32'h0000_0040) begin
      failures++;
      $display("FAIL flush_rsv got=%h want=00000040", BUSY_O);
    end
  endtask

  task automatic test_zero();
    RD_I_ADDR = {5'd6, 5'd0};
    step();
    wr(0, 5'd0, 32'hFFFF_FFFF);
    RSV_I_EN   = 1'b1;
    RSV_I_ADDR = 5'd0;
    #2;
    checks++;
    if (RD_O_DATA[31:0] !== 32'h0 || RD_O_VALID[0] !== 1'b1) begin
      failures++;
      $display("FAIL x0_no_fwd got=%h/%b want=0/1", RD_O_DATA[31:0], RD_O_VALID[0]);
    end
    step();
    idle_writes();
    #2;
    checks++;
    if (RD_O_DATA[31:0] !== 32'h0 || RD_O_VALID[0] !== 1'b1 || BUSY_O[0] !== 1'b0) begin
      failures++;
      $display("FAIL x0_after got=%h/valid%b/busy%b want=0/1/0",
               RD_O_DATA[31:0], RD_O_VALID[0], BUSY_O[0]);
    end
    checks++;
    if (RD_O_VALID[1] !== 1'b0) begin
      failures++;
      $display("FAIL x6_pending got=%b want=0", RD_O_VALID[1]);
    end
  endtask

  task automatic test_reset_mid();
    wr(1, 5'd12, 32'h77);
    step();
    idle_writes();
    RST = 1'b1;
    wr(0, 5'd10, 32'hAA);
    RSV_I_EN   = 1'b1;
    RSV_I_ADDR = 5'd11;
    RD_I_ADDR  = {5'd12, 5'd10};
    step();
    RST = 1'b0;
    idle_writes();
    #2;
    checks++;
    if (RD_O_ADDR !== 10'h0 || BUSY_O !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_state got=addr%h/busy%h want=0/0", RD_O_ADDR, BUSY_O);
    end
    step();
    #2;
    checks++;
    if (RD_O_DATA !== 64'h0 || RD_O_VALID !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_read got=%h/%b want=0/11", RD_O_DATA, RD_O_VALID);
    end
  endtask

  initial begin
    RST       = 1'b1;
    RD_I_ADDR = '0;
    idle_writes();
    test_reset();
    test_write_read();
    test_forward();
    test_scoreboard();
    test_flush();
    test_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
